// File: rtl/call_stack_pkg.sv
// Shared types and sizing helpers for the CALL/RET stack controller.
package call_stack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_DRAIN,
    S_LOAD,
    S_ERR
  } state_t;

  // Number of stack words needed to hold one return address.
  function automatic int calc_nib(input int pc_width, input int data_size);
    return pc_width / data_size;
  endfunction

  // Whole frames that fit in the 2**stack_size-1 usable stack entries.
  function automatic int calc_max_frames(input int stack_size, input int nib);
    return ((2 ** stack_size) - 1) / nib;
  endfunction

endpackage

// File: rtl/call_stack_ctrl.sv
// CALL/RET controller: serialises return addresses onto the nibble stack and drives PC loads.
// Build option CALLSTK_STICKY_ERR_EN makes err_overflow/err_underflow hold until RSTN.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int DATA_SIZE  = 4,
  parameter int STACK_SIZE = 4,
  parameter int PC_WIDTH   = 8,
  localparam int NIB        = calc_nib(PC_WIDTH, DATA_SIZE),
  localparam int MAX_FRAMES = calc_max_frames(STACK_SIZE, NIB),
  localparam int DEPTH_W    = $clog2(MAX_FRAMES + 1)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 call_req,
  input  logic                 ret_req,
  input  logic [PC_WIDTH-1:0]  ret_addr,
  input  logic [PC_WIDTH-1:0]  target_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  pc_load_addr,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic [DEPTH_W-1:0]   depth,
  output logic                 stk_w,
  output logic                 stk_r,
  output logic [DATA_SIZE-1:0] stk_data_wr,
  input  logic [DATA_SIZE-1:0] stk_data_rd,
  input  logic                 stk_full,
  input  logic                 stk_empty,
  output state_t               state_dbg
);

`ifdef CALLSTK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0]   LAST = CNT_W'(NIB - 1);
  localparam logic [DEPTH_W-1:0] MAXD = DEPTH_W'(MAX_FRAMES);

  // Request protocol: call_req/ret_req are single-cycle pulses acting as "valid";
  // the block is "ready" only in IDLE with busy=0, and anything else is dropped.
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PC_WIDTH-1:0] push_sh;
  logic [PC_WIDTH-1:0] tgt_q;
  logic [PC_WIDTH-1:0] ret_q;
  logic [PC_WIDTH-1:0] ret_next;
  logic                pend_ovf;
  logic                pend_unf;

  assign state_dbg = state;

  always_comb begin
    ret_next = (ret_q << DATA_SIZE) | PC_WIDTH'(stk_data_rd);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= S_IDLE;
      cnt           <= '0;
      push_sh       <= '0;
      tgt_q         <= '0;
      ret_q         <= '0;
      pend_ovf      <= 1'b0;
      pend_unf      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_addr  <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      depth         <= '0;
      stk_w         <= 1'b0;
      stk_r         <= 1'b0;
      stk_data_wr   <= '0;
    end else begin
      if (!STICKY) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end
      done    <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (call_req) begin
            if (depth == MAXD) begin
              state        <= S_ERR;
              done         <= 1'b1;
              err_overflow <= 1'b1;
            end else begin
              state       <= S_PUSH;
              cnt         <= '0;
              busy        <= 1'b1;
              stk_w       <= 1'b1;
              stk_data_wr <= ret_addr[DATA_SIZE-1:0];
              push_sh     <= ret_addr >> DATA_SIZE;
              tgt_q       <= target_addr;
              pend_ovf    <= 1'b0;
            end
          end else if (ret_req) begin
            if (depth == '0) begin
              state         <= S_ERR;
              done          <= 1'b1;
              err_underflow <= 1'b1;
            end else begin
              state    <= S_POP;
              cnt      <= '0;
              busy     <= 1'b1;
              stk_r    <= 1'b1;
              pend_unf <= 1'b0;
            end
          end
        end
        S_PUSH: begin
          if (stk_full) pend_ovf <= 1'b1;
          if (cnt == LAST) begin
            state        <= S_LOAD;
            stk_w        <= 1'b0;
            stk_data_wr  <= '0;
            pc_load      <= 1'b1;
            pc_load_addr <= tgt_q;
            done         <= 1'b1;
            depth        <= depth + DEPTH_W'(1);
            if (pend_ovf || stk_full) err_overflow <= 1'b1;
          end else begin
            cnt         <= cnt + CNT_W'(1);
            stk_data_wr <= push_sh[DATA_SIZE-1:0];
            push_sh     <= push_sh >> DATA_SIZE;
          end
        end
        S_POP: begin
          if (stk_empty) pend_unf <= 1'b1;
          // Read data lags stk_r by one cycle, so the first pop has nothing to capture yet.
          if (cnt != '0) ret_q <= ret_next;
          if (cnt == LAST) begin
            state <= S_DRAIN;
            stk_r <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          ret_q        <= ret_next;
          state        <= S_LOAD;
          pc_load      <= 1'b1;
          pc_load_addr <= ret_next;
          done         <= 1'b1;
          depth        <= depth - DEPTH_W'(1);
          if (pend_unf) err_underflow <= 1'b1;
        end
        S_LOAD: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_ERR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          stk_w <= 1'b0;
          stk_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with a behavioural 15-entry nibble stack alongside.
module tb_call_stack_ctrl;
  import call_stack_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       call_req = 1'b0;
  logic       ret_req = 1'b0;
  logic [7:0] ret_addr = '0;
  logic [7:0] target_addr = '0;
  logic       busy, done, pc_load, err_overflow, err_underflow;
  logic [7:0] pc_load_addr;
  logic [2:0] depth;
  logic       stk_w, stk_r, stk_full, stk_empty;
  logic [3:0] stk_data_wr;
  logic [3:0] stk_data_rd;
  state_t     state_dbg;

  int n_checks = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  call_stack_ctrl #(.DATA_SIZE(4), .STACK_SIZE(4), .PC_WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .call_req(call_req), .ret_req(ret_req),
    .ret_addr(ret_addr), .target_addr(target_addr), .busy(busy), .done(done),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .depth(depth), .stk_w(stk_w), .stk_r(stk_r),
    .stk_data_wr(stk_data_wr), .stk_data_rd(stk_data_rd), .stk_full(stk_full),
    .stk_empty(stk_empty), .state_dbg(state_dbg)
  );

  // Nibble stack: 15 usable entries, registered read data.
  logic [3:0] smem [0:15];
  logic [3:0] scnt;
  assign stk_full  = (scnt == 4'd15);
  assign stk_empty = (scnt == 4'd0);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      scnt        <= '0;
      stk_data_rd <= '0;
    end else if (stk_w && !stk_full) begin
      smem[scnt] <= stk_data_wr;
      scnt       <= scnt + 4'd1;
    end else if (stk_r && !stk_empty) begin
      stk_data_rd <= smem[scnt - 4'd1];
      scnt        <= scnt - 4'd1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Request issued in cycle 0; returns in the first IDLE cycle after LOAD.
  task automatic do_call(input logic [7:0] ra, input logic [7:0] ta,
                         input logic [2:0] exp_d, input logic with_ret);
    call_req = 1'b1; ret_req = with_ret; ret_addr = ra; target_addr = ta;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
    ret_addr = 8'($urandom_range(0, 255)); target_addr = 8'($urandom_range(0, 255));
    check("call_c1_ctl", {29'd0, stk_w, stk_r, busy}, 32'b101);
    check("call_c1_dat", {28'd0, stk_data_wr}, {28'd0, ra[3:0]});
    tick();
    check("call_c2_ctl", {29'd0, stk_w, stk_r, busy}, 32'b101);
    check("call_c2_dat", {28'd0, stk_data_wr}, {28'd0, ra[7:4]});
    tick();
    check("call_c3_ld", {29'd0, pc_load, done, stk_w}, 32'b110);
    check("call_c3_addr", {24'd0, pc_load_addr}, {24'd0, ta});
    check("call_c3_depth", {29'd0, depth}, {29'd0, exp_d});
    tick();
    check("call_c4_idle", {30'd0, busy, pc_load}, 32'b00);
  endtask

  task automatic do_ret(input logic [7:0] exp_a, input logic [2:0] exp_d);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("ret_c1_ctl", {29'd0, stk_w, stk_r, busy}, 32'b011);
    tick();
    check("ret_c2_ctl", {29'd0, stk_w, stk_r, busy}, 32'b011);
    tick();
    check("ret_c3_drain", {29'd0, stk_r, pc_load, busy}, 32'b001);
    tick();
    check("ret_c4_ld", {29'd0, pc_load, done, stk_r}, 32'b110);
    check("ret_c4_addr", {24'd0, pc_load_addr}, {24'd0, exp_a});
    check("ret_c4_depth", {29'd0, depth}, {29'd0, exp_d});
    tick();
    check("ret_c5_idle", {30'd0, busy, pc_load}, 32'b00);
  endtask

  task automatic do_err(input logic is_call, input logic [2:0] exp_d);
    call_req = is_call; ret_req = ~is_call;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
    check("err_c1_ctl", {27'd0, done, busy, stk_w, stk_r, pc_load}, 32'b10000);
    check("err_c1_flag", {31'd0, is_call ? err_overflow : err_underflow}, 32'd1);
    check("err_c1_depth", {29'd0, depth}, {29'd0, exp_d});
    tick();
    check("err_c2_ctl", {28'd0, done, busy, stk_w, stk_r}, 32'b0000);
`ifdef CALLSTK_STICKY_ERR_EN
    check("err_c2_sticky", {31'd0, is_call ? err_overflow : err_underflow}, 32'd1);
`else
    check("err_c2_pulse", {31'd0, is_call ? err_overflow : err_underflow}, 32'd0);
`endif
  endtask

  initial begin
    #2;
    check("reset_outs", {busy, done, pc_load, pc_load_addr, err_overflow, err_underflow,
                         stk_w, stk_r, stk_data_wr, depth}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge CLK);
    RSTN = 1'b1;
    tick();

    do_call(8'h3C, 8'hA5, 3'd1, 1'b0);
    do_ret(8'h3C, 3'd0);

    for (int i = 0; i < 7; i++) do_call(8'(8'h10 + i), 8'(8'h80 + i), 3'(i + 1), 1'b0);
    do_err(1'b1, 3'd7);
    for (int i = 0; i < 7; i++) do_ret(8'(8'h16 - i), 3'(6 - i));

    do_err(1'b0, 3'd0);

    do_call(8'h21, 8'h42, 3'd1, 1'b0);
    do_call(8'h9E, 8'hE9, 3'd2, 1'b1);
    do_ret(8'h9E, 3'd1);
    do_ret(8'h21, 3'd0);

    // Reset during the second push cycle.
    call_req = 1'b1; ret_addr = 8'h77; target_addr = 8'h88;
    tick();
    call_req = 1'b0;
    tick();
    check("rst_mid_pre", {31'd0, stk_w}, 32'd1);
    RSTN = 1'b0;
    #1;
    check("rst_mid_outs", {busy, done, pc_load, pc_load_addr, err_overflow, err_underflow,
                           stk_w, stk_r, stk_data_wr, depth}, 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    do_err(1'b0, 3'd0);

    do_call(8'h55, 8'h66, 3'd1, 1'b0);
`ifdef CALLSTK_STICKY_ERR_EN
    check("sticky_after_call", {31'd0, err_underflow}, 32'd1);
`else
    check("nosticky_after_call", {31'd0, err_underflow}, 32'd0);
`endif
    check("final_depth", {29'd0, depth}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
